// File: rtl/shared_bus_reader.sv
// shared_bus_reader
//   Receiving end of the shared tristate project data bus. Owns the one-hot
//   drive enables of all wrapped projects, switches between them with
//   break-before-make dead cycles, and serves a single Wishbone classic read
//   slave that forwards reads to the active project and captures the bus.
//
// Ports
//   wb_clk_i, wb_rst_n_i    clock, asynchronous active-low reset
//   sel_i, sel_valid_i      project switch request (one-cycle pulse)
//   sel_busy_o              switch in progress, new requests ignored
//   active_o                one-hot (or zero) project drive enables
//   wbs_cyc_i, wbs_stb_i    Wishbone read request
//   wbs_ack_o, wbs_err_o    one-cycle read response
//   wbs_dat_o               captured read data
//   proj_stb_o              read request towards the active project
//   proj_ack_i              per-project data-valid acknowledge
//   bus_dat_i               shared data bus as seen at the receiver
module shared_bus_reader #(
    parameter int unsigned NUM_PROJ    = 2,
    parameter int unsigned SEL_W       = 1,
    parameter int unsigned DW          = 32,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic [SEL_W-1:0]    sel_i,
    input  logic                sel_valid_i,
    output logic                sel_busy_o,
    output logic [NUM_PROJ-1:0] active_o,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    output logic                wbs_ack_o,
    output logic                wbs_err_o,
    output logic [DW-1:0]       wbs_dat_o,
    output logic                proj_stb_o,
    input  logic [NUM_PROJ-1:0] proj_ack_i,
    input  logic [DW-1:0]       bus_dat_i
);

    localparam int unsigned TurnW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [TurnW-1:0] TurnLoad = TurnW'(TURN_CYCLES - 1);
    localparam logic [7:0] TmoLoad = 8'(TIMEOUT);

    typedef enum logic [1:0] {SelNone, SelDrain, SelTurn, SelOn} sel_state_e;
    typedef enum logic [1:0] {RdIdle, RdWait, RdResp} rd_state_e;

    sel_state_e       sel_state_q, sel_state_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic [SEL_W-1:0] cur_q, cur_d;   // index driving while ON
    logic [SEL_W-1:0] tgt_q, tgt_d;   // index latched at request time
    logic             pend_q, pend_d; // switch deferred behind a read
    logic [TurnW-1:0] turn_cnt_q, turn_cnt_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic             resp_err_q, resp_err_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [DW-1:0]    dat_q, dat_d;

    logic sel_ok;
    logic rd_req;
    logic rd_start;
    logic rd_hold;

    assign sel_busy_o = pend_q || (sel_state_q == SelDrain) || (sel_state_q == SelTurn);
    assign sel_ok     = sel_valid_i && (32'(sel_i) < NUM_PROJ) && !sel_busy_o;

    // The response flags block re-acceptance of a strobe the master still holds.
    assign rd_req   = wbs_cyc_i && wbs_stb_i && !ack_q && !err_q;
    assign rd_start = (rd_state_q == RdIdle) && rd_req && (sel_state_q == SelOn);
    // Enables must not drop while a read is waiting on (or just issued to) a project.
    assign rd_hold  = (rd_state_q == RdWait) || rd_start;

    assign proj_stb_o = (rd_state_q == RdWait);
    assign wbs_ack_o  = ack_q;
    assign wbs_err_o  = err_q;
    assign wbs_dat_o  = dat_q;

    always_comb begin
        active_o = '0;
        if (sel_state_q == SelOn) begin
            for (int unsigned i = 0; i < NUM_PROJ; i++) begin
                active_o[i] = (cur_q == SEL_W'(i));
            end
        end
    end

    // Selection FSM
    always_comb begin
        sel_state_d = sel_state_q;
        cur_d       = cur_q;
        tgt_d       = tgt_q;
        pend_d      = pend_q;
        turn_cnt_d  = turn_cnt_q;
        case (sel_state_q)
            SelNone: begin
                if (sel_ok) begin
                    tgt_d       = sel_i;
                    turn_cnt_d  = TurnLoad;
                    sel_state_d = SelTurn;
                end
            end
            SelOn: begin
                if (sel_ok) begin
                    tgt_d  = sel_i;
                    pend_d = 1'b1;
                end
                if ((sel_ok || pend_q) && !rd_hold) begin
                    pend_d      = 1'b0;
                    sel_state_d = SelDrain;
                end
            end
            SelDrain: begin
                turn_cnt_d  = TurnLoad;
                sel_state_d = SelTurn;
            end
            SelTurn: begin
                if (turn_cnt_q == '0) begin
                    cur_d       = tgt_q;
                    sel_state_d = SelOn;
                end else begin
                    turn_cnt_d = turn_cnt_q - TurnW'(1);
                end
            end
            default: sel_state_d = SelNone;
        endcase
    end

    // Read FSM; the response is registered out of RdResp, so it is visible
    // in the following (idle) cycle.
    always_comb begin
        rd_state_d = rd_state_q;
        tmo_cnt_d  = tmo_cnt_q;
        resp_err_d = resp_err_q;
        dat_d      = dat_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        case (rd_state_q)
            RdIdle: begin
                if (rd_req) begin
                    if (sel_state_q == SelOn) begin
                        tmo_cnt_d  = TmoLoad;
                        rd_state_d = RdWait;
                    end else begin
                        resp_err_d = 1'b1;
                        rd_state_d = RdResp;
                    end
                end
            end
            RdWait: begin
                if (!wbs_cyc_i) begin
                    rd_state_d = RdIdle;
                end else if (proj_ack_i[cur_q]) begin
                    dat_d      = bus_dat_i;
                    resp_err_d = 1'b0;
                    rd_state_d = RdResp;
                end else if (tmo_cnt_q <= 8'd1) begin
                    // TIMEOUT wait cycles have elapsed without an ack
                    resp_err_d = 1'b1;
                    rd_state_d = RdResp;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 8'd1;
                end
            end
            RdResp: begin
                ack_d      = !resp_err_q;
                err_d      = resp_err_q;
                rd_state_d = RdIdle;
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sel_state_q <= SelNone;
            rd_state_q  <= RdIdle;
            cur_q       <= '0;
            tgt_q       <= '0;
            pend_q      <= 1'b0;
            turn_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            resp_err_q  <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            sel_state_q <= sel_state_d;
            rd_state_q  <= rd_state_d;
            cur_q       <= cur_d;
            tgt_q       <= tgt_d;
            pend_q      <= pend_d;
            turn_cnt_q  <= turn_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            resp_err_q  <= resp_err_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
        end
    end

endmodule

// File: tb/tb_shared_bus_reader.sv
// tb_shared_bus_reader
//   Directed table-driven bench for shared_bus_reader. Each table row holds
//   the outputs expected during a cycle and the inputs driven in that cycle;
//   reset corner cases are hand-written sequences afterwards.
module tb_shared_bus_reader;

    localparam int unsigned NUM_PROJ    = 2;
    localparam int unsigned SEL_W       = 1;
    localparam int unsigned DW          = 32;
    localparam int unsigned TURN_CYCLES = 2;
    localparam int unsigned TIMEOUT     = 15;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [SEL_W-1:0]    sel = '0;
    logic                sel_valid = 1'b0;
    logic                sel_busy;
    logic [NUM_PROJ-1:0] active;
    logic                cyc = 1'b0;
    logic                stb = 1'b0;
    logic                ack;
    logic                err;
    logic [DW-1:0]       dat;
    logic                pstb;
    logic [NUM_PROJ-1:0] pack = '0;
    logic [DW-1:0]       bus = '0;

    shared_bus_reader #(
        .NUM_PROJ    (NUM_PROJ),
        .SEL_W       (SEL_W),
        .DW          (DW),
        .TURN_CYCLES (TURN_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .sel_i       (sel),
        .sel_valid_i (sel_valid),
        .sel_busy_o  (sel_busy),
        .active_o    (active),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_ack_o   (ack),
        .wbs_err_o   (err),
        .wbs_dat_o   (dat),
        .proj_stb_o  (pstb),
        .proj_ack_i  (pack),
        .bus_dat_i   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_PROJ-1:0] e_act;
        logic                e_busy;
        logic                e_pstb;
        logic                e_ack;
        logic                e_err;
        logic [DW-1:0]       e_dat;
        logic [SEL_W-1:0]    sel;
        logic                sv;
        logic                cs;
        logic [NUM_PROJ-1:0] pack;
        logic [DW-1:0]       bus;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [NUM_PROJ-1:0] e_act, input logic e_busy, input logic e_pstb,
                       input logic e_ack, input logic e_err, input logic [DW-1:0] e_dat,
                       input logic [SEL_W-1:0] s, input logic sv, input logic cs,
                       input logic [NUM_PROJ-1:0] pa, input logic [DW-1:0] b);
        vec_t v;
        v.e_act = e_act; v.e_busy = e_busy; v.e_pstb = e_pstb; v.e_ack = e_ack;
        v.e_err = e_err; v.e_dat = e_dat; v.sel = s; v.sv = sv; v.cs = cs;
        v.pack = pa; v.bus = b;
        vecs.push_back(v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".active"}, 64'(active), 64'd0);
        chk({tag, ".busy"}, 64'(sel_busy), 64'd0);
        chk({tag, ".ack"}, 64'(ack), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'd0);
        chk({tag, ".pstb"}, 64'(pstb), 64'd0);
        chk({tag, ".dat"}, 64'(dat), 64'd0);
    endtask

    // Issue a read with nothing selected and expect a single error response.
    task automatic read_expect_err(input string tag);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        chk({tag, ".err_early"}, 64'(err), 64'd0);
        chk({tag, ".pstb"}, 64'(pstb), 64'd0);
        @(negedge clk);
        chk({tag, ".err"}, 64'(err), 64'd1);
        chk({tag, ".ack"}, 64'(ack), 64'd0);
        chk({tag, ".active"}, 64'(active), 64'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk({tag, ".err_once"}, 64'(err), 64'd0);
    endtask

    initial begin
        logic [NUM_PROJ-1:0] last_nz;
        int                  zero_run;

        // No project: read errors two cycles after the strobe.
        add(2'b00, 0, 0, 0, 0, 32'h0, 0, 0, 1, 2'b00, 32'h0);
        add(2'b00, 0, 0, 0, 0, 32'h0, 0, 0, 1, 2'b00, 32'h0);
        add(2'b00, 0, 0, 0, 1, 32'h0, 0, 0, 0, 2'b00, 32'h0);
        // Select project 1; a request during the switch is ignored.
        add(2'b00, 0, 0, 0, 0, 32'h0, 1, 1, 0, 2'b00, 32'h0);
        add(2'b00, 1, 0, 0, 0, 32'h0, 0, 1, 0, 2'b00, 32'h0);
        add(2'b00, 1, 0, 0, 0, 32'h0, 0, 0, 0, 2'b00, 32'h0);
        // Project 1 active; read acked by project 1 in its fourth wait cycle.
        add(2'b10, 0, 0, 0, 0, 32'h0, 0, 0, 1, 2'b00, 32'h0);
        add(2'b10, 0, 1, 0, 0, 32'h0, 0, 0, 1, 2'b01, 32'h11111111);
        add(2'b10, 0, 1, 0, 0, 32'h0, 0, 0, 1, 2'b00, 32'h0);
        add(2'b10, 0, 1, 0, 0, 32'h0, 0, 0, 1, 2'b00, 32'h0);
        add(2'b10, 0, 1, 0, 0, 32'h0, 0, 0, 1, 2'b10, 32'hDEADBEEF);
        add(2'b10, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1, 2'b00, 32'h0);
        add(2'b10, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 2'b00, 32'h0);
        // Switch 1->0 issued mid-read: deferred until the read completes.
        add(2'b10, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1, 2'b00, 32'h0);
        add(2'b10, 0, 1, 0, 0, 32'hDEADBEEF, 0, 1, 1, 2'b00, 32'h0);
        add(2'b10, 1, 1, 0, 0, 32'hDEADBEEF, 0, 0, 1, 2'b00, 32'h0);
        add(2'b10, 1, 1, 0, 0, 32'hDEADBEEF, 0, 0, 1, 2'b10, 32'hCAFEF00D);
        add(2'b10, 1, 0, 0, 0, 32'hCAFEF00D, 0, 0, 1, 2'b00, 32'h0);
        add(2'b00, 1, 0, 1, 0, 32'hCAFEF00D, 0, 0, 0, 2'b00, 32'h0);
        add(2'b00, 1, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 2'b00, 32'h0);
        add(2'b00, 1, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 2'b00, 32'h0);
        // Project 0 never acks: 15 wait cycles, then error; data retained.
        add(2'b01, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 1, 2'b00, 32'h0);
        for (int k = 1; k <= 15; k++) begin
            add(2'b01, 0, 1, 0, 0, 32'hCAFEF00D, 0, 0, 1,
                (k == 3) ? 2'b10 : 2'b00, (k == 3) ? 32'h12345678 : 32'h0);
        end
        add(2'b01, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 1, 2'b00, 32'h0);
        // Strobe still held during the response: not re-accepted until next cycle.
        add(2'b01, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 1, 2'b00, 32'h0);
        add(2'b01, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 1, 2'b00, 32'h0);
        // Cycle dropped while waiting: read abandoned, no response.
        add(2'b01, 0, 1, 0, 0, 32'hCAFEF00D, 0, 0, 0, 2'b00, 32'h0);
        add(2'b01, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 2'b00, 32'h0);
        add(2'b01, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 2'b00, 32'h0);

        // Reset state
        #2;
        chk_all_zero("in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        last_nz  = '0;
        zero_run = 0;
        foreach (vecs[i]) begin
            @(negedge clk);
            chk($sformatf("row%0d.active", i), 64'(active), 64'(vecs[i].e_act));
            chk($sformatf("row%0d.busy", i), 64'(sel_busy), 64'(vecs[i].e_busy));
            chk($sformatf("row%0d.pstb", i), 64'(pstb), 64'(vecs[i].e_pstb));
            chk($sformatf("row%0d.ack", i), 64'(ack), 64'(vecs[i].e_ack));
            chk($sformatf("row%0d.err", i), 64'(err), 64'(vecs[i].e_err));
            chk($sformatf("row%0d.dat", i), 64'(dat), 64'(vecs[i].e_dat));
            chk($sformatf("row%0d.onehot", i), 64'($countones(active) <= 1), 64'd1);
            if (active == '0) begin
                zero_run++;
            end else begin
                if (last_nz != '0 && active != last_nz) begin
                    chk($sformatf("row%0d.deadcycles", i), 64'(zero_run >= TURN_CYCLES), 64'd1);
                end
                last_nz  = active;
                zero_run = 0;
            end
            sel       = vecs[i].sel;
            sel_valid = vecs[i].sv;
            cyc       = vecs[i].cs;
            stb       = vecs[i].cs;
            pack      = vecs[i].pack;
            bus       = vecs[i].bus;
        end

        // Reset asserted while a read waits on project 0.
        @(negedge clk);
        sel_valid = 1'b0; pack = '0; bus = '0;
        cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        chk("rwait.pstb_before", 64'(pstb), 64'd1);
        chk("rwait.active_before", 64'(active), 64'(2'b01));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_wait");
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        read_expect_err("after_rst_wait");

        // Reset asserted during the turnaround of a new selection.
        @(negedge clk);
        sel = 1'b1; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        chk("rturn.busy_before", 64'(sel_busy), 64'd1);
        chk("rturn.active_before", 64'(active), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_turn");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("after_rst_turn.active", 64'(active), 64'd0);
        chk("after_rst_turn.busy", 64'(sel_busy), 64'd0);
        read_expect_err("after_rst_turn");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_bus_reader.md
Name: shared_bus_reader

Overview:
- Receiving end of the shared tristate project data bus: generates the one-hot `active` enables for all wrapped projects and captures data driven onto the shared bus.
- Presents a single Wishbone classic read slave to the management side.
- Guarantees at most one project drives the bus, with break-before-make dead cycles on every handover.
- Times out silent projects with an error response.

Parameters:
- NUM_PROJ, 2, number of projects sharing the bus.
- SEL_W, 1, width of project index; must be at least clog2(NUM_PROJ), with a minimum of 1.
- DW, 32, shared data bus width.
- TURN_CYCLES, 2, dead cycles with all actives low between deselect and new select (minimum 1).
- TIMEOUT, 15, cycles waiting for project ack before error (minimum 1, at most 255).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- sel_i  in  SEL_W  requested project index.
- sel_valid_i  in  1  one-cycle request to switch to sel_i.
- sel_busy_o  in/out: out  1  high while a switch is in progress.
- active_o  out  NUM_PROJ  one-hot (or zero) project drive enables.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe (read only; wbs_we_i is not provided).
- wbs_ack_o  out  1  read complete, one cycle.
- wbs_err_o  out  1  read failed (no project or timeout), one cycle.
- wbs_dat_o  out  DW  captured read data.
- proj_stb_o  out  1  read request to the active project.
- proj_ack_i  in  NUM_PROJ  per-project data-valid acknowledge.
- bus_dat_i  in  DW  shared tristate bus as seen at the receiver.

Behaviour:
- Decided: one clock; reset is asynchronous and active-low. Clock port is wb_clk_i, reset port is wb_rst_n_i.
- Reset values:
  - active_o=0
  - sel_busy_o=0
  - wbs_ack_o=0
  - wbs_err_o=0
  - wbs_dat_o=0
  - proj_stb_o=0
  - state=NONE
- Selection FSM: NONE, DRAIN, TURN, ON.
  - NONE: no project active. sel_valid_i with sel_i<NUM_PROJ goes to TURN. sel_i>=NUM_PROJ is ignored.
  - ON: sel_valid_i with a valid sel_i goes to DRAIN. active_o stays asserted while a read is in flight; the switch request is held internally until the read finishes. Requesting the currently active index still performs a full break-before-make cycle.
  - DRAIN: active_o=0 from the next cycle; proceed to TURN.
  - TURN: active_o=0 for exactly TURN_CYCLES cycles. Then active_o = 1<<sel latched at request time, and go to ON.
  - sel_busy_o is high from the cycle after an accepted sel_valid_i until the first cycle of ON.
  - A sel_valid_i arriving while sel_busy_o=1 is ignored.
- Invariant: popcount(active_o) <= 1 every cycle. Between any two distinct nonzero values of active_o there are at least TURN_CYCLES cycles with active_o=0.
- Read FSM: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: on wbs_cyc_i&wbs_stb_i while wbs_ack_o=0 and wbs_err_o=0:
    - If selection state is ON: assert proj_stb_o, load the timeout counter with TIMEOUT, go to R_WAIT.
    - Otherwise: go to R_RESP with an error.
  - R_WAIT: proj_stb_o held high.
    - On proj_ack_i[active index]=1: capture bus_dat_i into wbs_dat_o, drop proj_stb_o, go to R_RESP with ack.
    - proj_ack_i bits of inactive projects are ignored.
    - Counter decrements each cycle without ack. At zero: error response, drop proj_stb_o, and leave wbs_dat_o unchanged.
  - R_RESP: assert exactly one of wbs_ack_o or wbs_err_o for one cycle, then return to R_IDLE.
  - Response latency: ack arrives 2 cycles after the project ack cycle is sampled; minimum total request-to-ack is 3 cycles.
- If wbs_cyc_i drops during R_WAIT, the read is abandoned: proj_stb_o drops, and no response is generated.
- The new read can be accepted on the cycle after the response.
- Asynchronous reset mid-operation immediately forces all outputs to their reset values; no partial response is emitted.

Test Plan:
- Reset, then read with no project selected -> wbs_err_o pulses once 2 cycles after stb; active_o=00; wbs_ack_o stays 0.
- sel_i=1, sel_valid_i pulse from NONE, TURN_CYCLES=2 -> active_o=00 for 2 cycles, then 10; sel_busy_o high for exactly those cycles.
- Project 1 active, read; project 1 acks after 4 cycles with bus_dat_i=32'hDEADBEEF -> wbs_dat_o=DEADBEEF, single wbs_ack_o; proj_stb_o low after ack.
- Switch 1->0 issued mid-read -> active_o stays 10 until ack, then 00 for at least 2 cycles, then 01; popcount never exceeds 1.
- Active project never acks, TIMEOUT=15 -> wbs_err_o 16 cycles after proj_stb_o rises; wbs_dat_o retains its previous value; an inactive project's ack during the wait is ignored.
- wb_rst_n_i asserted during R_WAIT and during TURN -> all outputs 0 immediately; after release, a read errors until a new selection is made.
